// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings (MULT/MULTU/DIV/DIVU)
//   - sequencer state enum (IDLE/RUN/FIX)
//   - default operand width and iteration count
package muldiv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int ITER_DEF = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
//   Multiply: shift-add on {acc, q}; q holds the multiplier and collects the
//             low product bits, acc collects the high bits.
//   Divide:   restoring subtract on {acc, q}; acc is the partial remainder,
//             q shifts out dividend bits and shifts in quotient bits.
// Ports:
//   i_is_div  1     select divide step (1) or multiply step (0)
//   i_acc     XLEN  high half (accumulator / partial remainder)
//   i_q       XLEN  low half (multiplier / dividend-quotient)
//   i_m       XLEN  multiplicand / divisor magnitude
//   o_acc     XLEN  next high half
//   o_q       XLEN  next low half
import muldiv_pkg::*;

module muldiv_step #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_acc,
  input  logic [XLEN-1:0] i_q,
  input  logic [XLEN-1:0] i_m,
  output logic [XLEN-1:0] o_acc,
  output logic [XLEN-1:0] o_q
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_trial;
  logic [XLEN-1:0] w_diff;

  // Single shift-add or restoring-subtract step
  always_comb begin
    w_sum   = {(XLEN+1){1'b0}};
    w_trial = {(XLEN+1){1'b0}};
    w_diff  = {XLEN{1'b0}};
    o_acc   = i_acc;
    o_q     = i_q;
    if (i_is_div) begin
      // The partial remainder stays below the divisor, so when the trial
      // value is >= divisor the difference always fits in XLEN bits.
      w_trial = {i_acc, i_q[XLEN-1]};
      w_diff  = w_trial[XLEN-1:0] - i_m;
      if (w_trial >= {1'b0, i_m}) begin
        o_acc = w_diff;
        o_q   = {i_q[XLEN-2:0], 1'b1};
      end else begin
        o_acc = w_trial[XLEN-1:0];
        o_q   = {i_q[XLEN-2:0], 1'b0};
      end
    end else begin
      if (i_q[0]) begin
        w_sum = {1'b0, i_acc} + {1'b0, i_m};
      end else begin
        w_sum = {1'b0, i_acc};
      end
      o_acc = w_sum[XLEN:1];
      o_q   = {w_sum[0], i_q[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
//   An operation takes 1 issue edge, ITER RUN steps and one FIX edge that
//   applies sign correction and writes HI/LO (done pulses with the write).
//   ITER must equal XLEN.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   start, op          issue pulse and opcode (sampled only in IDLE)
//   rs_val, rt_val     multiplicand/dividend, multiplier/divisor
//   flush              abort the operation in flight
//   hilo_rd            MFHI/MFLO in EX (only affects stall)
//   mthi, mtlo, wdata  HI/LO writes, honoured in IDLE without start
//   busy, stall, done  status; stall is combinational
//   hi, lo             architectural HI/LO
//   div0               (only with MULDIV_DIVZERO_FLAG_EN) sticky
//                      divide-by-zero flag, cleared by the next start
import muldiv_pkg::*;

module muldiv_sequencer #(
  parameter int XLEN = XLEN_DEF,
  parameter int ITER = ITER_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            flush,
  input  logic            hilo_rd,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
`ifdef MULDIV_DIVZERO_FLAG_EN
  ,
  output logic            div0
`endif
);

  localparam int CW = $clog2(ITER);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_acc;
  logic [XLEN-1:0]   r_q;
  logic [XLEN-1:0]   r_m;
  logic              r_is_div;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic              r_done;

  logic              w_op_div;
  logic              w_op_signed;
  logic              w_div_zero;
  logic [XLEN-1:0]   w_rs_mag;
  logic [XLEN-1:0]   w_rt_mag;
  logic [XLEN-1:0]   w_acc_nxt;
  logic [XLEN-1:0]   w_q_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_neg;
  logic [XLEN-1:0]   w_hi_fix;
  logic [XLEN-1:0]   w_lo_fix;

  assign w_op_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign w_op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_div_zero  = w_op_div && (rt_val == {XLEN{1'b0}});

  // Signed ops run on magnitudes; the most negative value maps onto itself,
  // which is the correct unsigned magnitude.
  assign w_rs_mag = (w_op_signed && rs_val[XLEN-1]) ?
                    (~rs_val + {{(XLEN-1){1'b0}}, 1'b1}) : rs_val;
  assign w_rt_mag = (w_op_signed && rt_val[XLEN-1]) ?
                    (~rt_val + {{(XLEN-1){1'b0}}, 1'b1}) : rt_val;

  assign busy  = (r_state != IDLE);
  assign stall = busy & (start | hilo_rd | mthi | mtlo);
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_q      (r_q),
    .i_m      (r_m),
    .o_acc    (w_acc_nxt),
    .o_q      (w_q_nxt)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush wins over the FIX completion
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (flush) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == CW'(ITER - 1)) begin
          w_state_nxt = FIX;
        end else begin
          w_state_nxt = RUN;
        end
      end
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sign correction of the raw unsigned result
  always_comb begin
    w_prod     = {r_acc, r_q};
    w_prod_neg = ~w_prod + {{(2*XLEN-1){1'b0}}, 1'b1};
    w_hi_fix   = r_acc;
    w_lo_fix   = r_q;
    if (r_is_div) begin
      w_hi_fix = r_neg_r ? (~r_acc + {{(XLEN-1){1'b0}}, 1'b1}) : r_acc;
      w_lo_fix = r_neg_q ? (~r_q + {{(XLEN-1){1'b0}}, 1'b1}) : r_q;
    end else if (r_neg_q) begin
      {w_hi_fix, w_lo_fix} = w_prod_neg;
    end else begin
      {w_hi_fix, w_lo_fix} = w_prod;
    end
  end

  // Datapath, counter and HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= {CW{1'b0}};
      r_acc    <= {XLEN{1'b0}};
      r_q      <= {XLEN{1'b0}};
      r_m      <= {XLEN{1'b0}};
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= {XLEN{1'b0}};
      r_lo     <= {XLEN{1'b0}};
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt    <= {CW{1'b0}};
            r_acc    <= {XLEN{1'b0}};
            r_is_div <= w_op_div;
            if (w_div_zero) begin
              // Divisor 0 with raw dividend and no sign fix-up leaves
              // quotient all-ones and remainder equal to the raw dividend.
              r_m     <= {XLEN{1'b0}};
              r_q     <= rs_val;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else begin
              r_m     <= w_rt_mag;
              r_q     <= w_rs_mag;
              r_neg_q <= w_op_signed & (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
              r_neg_r <= w_op_signed & w_op_div & rs_val[XLEN-1];
            end
          end else begin
            if (mthi) begin
              r_hi <= wdata;
            end
            if (mtlo) begin
              r_lo <= wdata;
            end
          end
        end
        RUN: begin
          if (!flush) begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        FIX: begin
          if (!flush) begin
            r_hi   <= w_hi_fix;
            r_lo   <= w_lo_fix;
            r_done <= 1'b1;
          end
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef MULDIV_DIVZERO_FLAG_EN
  logic r_dz;
  logic r_div0;

  // Sticky divide-by-zero flag, set with done, cleared by the next start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dz   <= 1'b0;
      r_div0 <= 1'b0;
    end else if ((r_state == IDLE) && start) begin
      r_dz   <= w_div_zero;
      r_div0 <= 1'b0;
    end else if ((r_state == FIX) && !flush && r_dz) begin
      r_div0 <= 1'b1;
    end
  end

  assign div0 = r_div0;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: each issued operation pushes its
// hand-computed {hi,lo} into a queue; the monitor pops and compares on done.
import muldiv_pkg::*;

module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_val = 32'h0;
  logic [31:0] rt_val = 32'h0;
  logic        flush = 1'b0;
  logic        hilo_rd = 1'b0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic        busy, stall, done;
  logic [31:0] hi, lo;
`ifdef MULDIV_DIVZERO_FLAG_EN
  logic        div0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int done_mark;
  logic [63:0] exp_q[$];

  muldiv_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .hilo_rd(hilo_rd),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
`ifdef MULDIV_DIVZERO_FLAG_EN
    , .div0(div0)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compare HI/LO against the scoreboard whenever done pulses
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got hi=%h lo=%h with nothing expected", hi, lo);
      end else begin
        check("result_hilo", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) begin
      @(posedge clk);
      #1;
    end
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: busy still %b after 100 cycles, expected 0", busy);
    end
  endtask

  // Issue an op; returns 1 time unit after the issue edge
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input bit expect_done);
    wait_idle();
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    if (expect_done) exp_q.push_back({eh, el});
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    cycles(3);
    @(negedge clk);
    check("reset_hilo", {hi, lo}, 64'h0);
    check("reset_flags", {61'h0, busy, done, stall}, 64'h0);
    rst_n = 1'b1;
    cycles(1);

    // MULTU with exact latency checks
    issue(OP_MULTU, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE, 1'b1);
    done_mark = n_done;
    check("busy_after_issue", {63'h0, busy}, 64'h1);
    cycles(32);
    check("busy_at_e32", {62'h0, busy, done}, 64'h2);
    cycles(1);
    check("done_at_e33", {62'h0, busy, done}, 64'h1);
    check("multu_hilo_e33", {hi, lo}, 64'h00000001_FFFFFFFE);
    cycles(1);
    check("done_one_pulse", {63'h0, done}, 64'h0);
    check("done_count", 64'(n_done - done_mark), 64'h1);

    issue(OP_MULT,  32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1);
    issue(OP_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);
    issue(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b1);
    issue(OP_DIV,   32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 1'b1);
    issue(OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b1);
    issue(OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h1,        1'b1);
    issue(OP_MULTU, 32'h00010000, 32'h00010000, 32'h1,        32'h0,        1'b1);
    issue(OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, 1'b1);
    issue(OP_DIV,   32'hFFFFFFFB, 32'h0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
    issue(OP_DIVU,  32'h1234,     32'h0,        32'h1234,     32'hFFFFFFFF, 1'b1);
    wait_idle();
    @(negedge clk);
`ifdef MULDIV_DIVZERO_FLAG_EN
    check("div0_set", {63'h0, div0}, 64'h1);
    cycles(2);
    check("div0_sticky", {63'h0, div0}, 64'h1);
`endif

    // Stall: collision with a second start and with hilo_rd
    issue(OP_MULTU, 32'h3, 32'h5, 32'h0, 32'hF, 1'b1);
`ifdef MULDIV_DIVZERO_FLAG_EN
    check("div0_cleared", {63'h0, div0}, 64'h0);
`endif
    cycles(5);
    op = OP_DIVU; rs_val = 32'h9; rt_val = 32'h3; start = 1'b1;
    @(negedge clk);
    check("stall_on_start", {63'h0, stall}, 64'h1);
    cycles(1);
    start = 1'b0;
    cycles(4);
    hilo_rd = 1'b1;
    @(negedge clk);
    check("stall_on_hilo_rd", {63'h0, stall}, 64'h1);
    cycles(22);
    @(negedge clk);
    check("stall_in_fix", {62'h0, busy, stall}, 64'h3);
    cycles(1);
    @(negedge clk);
    check("stall_released", {62'h0, busy, stall}, 64'h0);
    hilo_rd = 1'b0;

    // MTHI/MTLO in IDLE
    mthi = 1'b1; wdata = 32'hA;
    cycles(1);
    mthi = 1'b0; mtlo = 1'b1; wdata = 32'hB;
    cycles(1);
    mtlo = 1'b0;
    check("mthi_mtlo", {hi, lo}, 64'h0000000A_0000000B);

    // MTLO coincident with start is dropped
    mtlo = 1'b1; wdata = 32'h55;
    issue(OP_MULTU, 32'h2, 32'h3, 32'h0, 32'h6, 1'b1);
    mtlo = 1'b0;
    check("mtlo_dropped", {32'h0, lo}, 64'hB);
    wait_idle();
    mthi = 1'b1; wdata = 32'hA;
    cycles(1);
    mthi = 1'b0; mtlo = 1'b1; wdata = 32'hB;
    cycles(1);
    mtlo = 1'b0;

    // Flush in RUN
    done_mark = n_done;
    issue(OP_DIV, 32'd100, 32'd7, 32'h0, 32'h0, 1'b0);
    cycles(20);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    check("flush_run_busy", {63'h0, busy}, 64'h0);
    check("flush_run_hilo", {hi, lo}, 64'h0000000A_0000000B);

    // Flush in FIX
    issue(OP_MULTU, 32'h3, 32'h5, 32'h0, 32'h0, 1'b0);
    cycles(32);
    check("fix_reached", {63'h0, busy}, 64'h1);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    check("flush_fix_busy", {62'h0, busy, done}, 64'h0);
    cycles(10);
    check("flush_fix_hilo", {hi, lo}, 64'h0000000A_0000000B);
    check("flush_no_done", 64'(n_done - done_mark), 64'h0);

    // Flush in IDLE
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    check("flush_idle", {31'h0, busy, hi}, 64'hA);

    // Reset mid-RUN
    issue(OP_MULTU, 32'hFFFF, 32'hFFFF, 32'h0, 32'h0, 1'b0);
    cycles(15);
    rst_n = 1'b0;
    #1;
    check("rst_mid_hilo", {hi, lo}, 64'h0);
    check("rst_mid_busy", {62'h0, busy, done}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);

    issue(OP_MULT, 32'hFFFFFFF9, 32'h6, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b1);
    wait_idle();
    @(negedge clk);
    cycles(2);
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit with a HI/LO register pair, sitting beside the ALU in the execute stage.
- Sequences MULT/MULTU/DIV/DIVU over 33 cycles.
- Raises a stall request to the hazard logic while a new mul/div or a HI/LO access collides with an operation in flight.
- Owns the architectural HI/LO registers, which MFHI/MFLO read and MTHI/MTLO write.

Parameters:
- XLEN, 32, operand width; HI and LO are each XLEN wide.
- ITER, 32, number of iteration cycles; must equal XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  issue pulse; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_val  in  XLEN  multiplicand / dividend
- rt_val  in  XLEN  multiplier / divisor
- flush  in  1  abort the operation in flight (branch/exception squash)
- hilo_rd  in  1  MFHI/MFLO in EX this cycle
- mthi  in  1  write HI from wdata
- mtlo  in  1  write LO from wdata
- wdata  in  XLEN  MTHI/MTLO data
- busy  out  1  state != IDLE
- stall  out  1  pipeline freeze request
- done  out  1  one-cycle pulse when HI/LO are updated
- hi  out  XLEN  HI register
- lo  out  XLEN  LO register

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, hi=0, lo=0.
  - busy=0, done=0, stall=0; internal accumulators cleared.
- States:
  - IDLE: start=1 → RUN. Latch |rs|, |rt| (signed ops) or raw values (unsigned ops), the op, and the result signs; counter=0.
  - RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle. counter increments; after counter==ITER-1 → FIX. Exactly 32 RUN cycles.
  - FIX: apply sign correction, write hi/lo, assert done for that cycle, → IDLE.
- Latency: start sampled at edge E0 → hi/lo valid and done=1 after edge E33. busy is high from after E0 to after E33.
- Multiply:
  - {hi,lo} = 64-bit product.
  - MULT: negate the product if operand signs differ.
- Divide:
  - lo = quotient, hi = remainder.
  - Signed: quotient is negative if the signs differ; remainder takes the dividend's sign.
  - 0x80000000 / -1 gives lo=0x80000000, hi=0.
- Divide by zero (rt_val=0), both DIV and DIVU:
  - lo=0xFFFFFFFF, hi=rs_val (raw).
  - Same 33-cycle latency.
- stall = busy & (start | hilo_rd | mthi | mtlo). Combinational; asserted on the cycle of the collision.
- start while busy: ignored (the hazard logic holds the instruction via stall).
- mthi/mtlo in IDLE: write on the next edge.
- mthi/mtlo coincident with start in IDLE: start wins and the write is dropped (illegal in a single-issue pipe).
- flush:
  - In RUN or FIX: next state is IDLE; hi/lo keep their pre-operation values; no done.
  - In IDLE: no effect.
  - flush has priority over FIX completion.
- Reset mid-operation: immediate return to the reset values above.

Optional Feature:
- MULDIV_DIVZERO_FLAG_EN
- Defined: adds output port div0 (1 bit), a sticky flag.
  - Set with done when a DIV/DIVU had rt_val=0.
  - Cleared by the next start or by reset.
- Undefined: no div0 port. Results for divide-by-zero are unchanged.

Decomposition:
- Package muldiv_pkg:
  - op encoding constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU).
  - state enum (IDLE, RUN, FIX).
  - ITER default.
- Sub-module muldiv_step: combinational single-iteration datapath (shift-add or restoring subtract on {rem/acc, q/mplier}).
- The sequencer keeps the FSM, counter, sign handling and the HI/LO registers.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=2 → after 33 cycles hi=0x00000001, lo=0xFFFFFFFE; done pulses once; busy low after.
- MULT rs=-3, rt=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV rs=-7, rt=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU rs=0x1234, rt=0 → lo=0xFFFFFFFF, hi=0x1234. With MULDIV_DIVZERO_FLAG_EN, div0=1 until the next start.
- Start MULTU, then hilo_rd=1 at cycle 10 → stall=1 until done. Second start at cycle 5 → stall=1, and no effect on the in-flight result.
- Preload hi=0xA via mthi, then start DIV with flush at cycle 20 → busy drops next cycle, no done, hi=0xA. Repeat with rst_n low mid-RUN → hi=lo=0, busy=0 immediately.
